srlz_tx_scheduler: RTL
======================

# srlz_tx_scheduler

Transmit-side controller for the PISO serializer. Accepts parallel words from N_REQ requesters over valid/ready handshakes, arbitrates round-robin, and sequences the serializer through load, shift and inter-frame gap phases. Sits between the channel sources and the serializer in the transceiver TX path. It owns all serializer control, so the serializer itself holds no control logic.

## Interface
- DATA_WIDTH, 8, bits per word; the serializer shifts LSB first.
- N_REQ, 4, number of requesters, minimum 2.
- GAP_CYCLES, 2, idle cycles between frames, minimum 0.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  when low, no new grant is issued; a frame in progress completes.
- req_valid  in  N_REQ  per-requester word valid.
- req_data  in  N_REQ*DATA_WIDTH  packed words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  out  N_REQ  one-hot handshake; the word transfers when valid and ready are both high.
- srl_load  out  1  one-cycle pulse that loads srl_data into the serializer.
- srl_data  out  DATA_WIDTH  captured word; held stable from LOAD through the end of SHIFT.
- srl_shift  out  1  shift enable to the serializer.
- ch_id  out  clog2(N_REQ)  index of the channel currently being transmitted.
- tx_busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse on the last shift cycle.

## Operation
- The FSM has four states: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - If enable is high and any req_valid is high, grant the first valid requester at or after (last_grant+1) mod N_REQ.
  - req_ready[grant] is high combinationally in that cycle.
  - Capture req_data and the grant index, then go to LOAD.
- LOAD: srl_load=1; bit counter cleared; go to SHIFT.
- SHIFT:
  - srl_shift=1 for exactly DATA_WIDTH-1 cycles.
  - The counter increments each cycle. At count DATA_WIDTH-2, pulse frame_done.
  - Next state is GAP, or IDLE when GAP_CYCLES=0.
- GAP: all serializer controls low for GAP_CYCLES cycles, then go to IDLE.
- last_grant updates only on a completed handshake.
- Requesters must hold valid and data until ready. Withdrawing valid before a grant is legal and simply removes that requester from arbitration.
- req_ready is never high outside IDLE and is never high for more than one bit.
- Reset values: state=IDLE, last_grant=N_REQ-1 (so channel 0 wins first), all outputs 0, srl_data=0, ch_id=0.
- Reset mid-frame: the frame is aborted, the next cycle is IDLE, and no frame_done is issued.
- enable dropped mid-frame: the frame continues through GAP normally.
- enable low in IDLE: req_ready stays 0 and the arbiter pointer is frozen.

## Timing
- Word accepted in cycle t:
  - srl_load at t+1.
  - srl_shift at t+2 .. t+DATA_WIDTH.
  - frame_done at t+DATA_WIDTH.
  - GAP at t+DATA_WIDTH+1 .. t+DATA_WIDTH+GAP_CYCLES.
  - Earliest next accept at t+DATA_WIDTH+1+GAP_CYCLES.
- Back-to-back frame period is DATA_WIDTH+1+GAP_CYCLES cycles; 11 with the default parameters.
- All outputs are registered except req_ready, which is combinational from state, enable, req_valid and last_grant.
- Counter width is clog2(DATA_WIDTH). DATA_WIDTH=2 gives a single shift cycle.

## Structure
- Shared package `srlz_pkg` holds:
  - the state encoding (IDLE/LOAD/SHIFT/GAP),
  - a clog2-based width constant function,
  - the default DATA_WIDTH.
- Sub-module `rr_arbiter` (N parameter):
  - inputs: req vector, last_grant, enable;
  - outputs: one-hot grant, grant index, any_grant.
  - It is purely combinational; the pointer register lives in the scheduler.
- Top level holds the FSM, the bit counter, the gap counter and the data/ch_id capture registers.

## Test plan
- Single requester: ch2 valid with 0xA5 at cycle 5, defaults.
  - Required: req_ready[2] at 5, srl_load at 6 with srl_data=0xA5 and ch_id=2.
  - Required: srl_shift cycles 7–13, frame_done at 13, tx_busy low again at 16.
- All four requesters valid continuously with data 0x11, 0x22, 0x33, 0x44.
  - Required: grants in order 0,1,2,3,0. Accepts spaced exactly 11 cycles apart.
- GAP_CYCLES=0 with two requesters valid.
  - Required: second accept 9 cycles after the first. No cycle in which srl_load and srl_shift are both high.
- enable low while ch1 is valid for 20 cycles.
  - Required: no req_ready. Once enable rises, the grant follows in the same cycle.
  - enable dropped during SHIFT: the frame still completes with frame_done.
- rst asserted on the 3rd SHIFT cycle.
  - Required: next cycle all outputs 0 and state IDLE; no frame_done; next grant goes to ch0.
- Requester withdraws valid before being granted while another frame is active.
  - Required: it is skipped, and the pointer advances only on completed handshakes.

Source files
------------

// File: rtl/srlz_pkg.sv
`default_nettype none
// ============================================================================
// Module   : srlz_pkg
// Brief    : Shared state encoding and width helpers for the TX scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package srlz_pkg;

    localparam int c_default_data_width = 8;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_shift = 2'd2;
    localparam logic [1:0] c_st_gap   = 2'd3;

    // Never returns 0, so degenerate parameters still yield a legal vector.
    function automatic int calc_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick starting after last_grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import srlz_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = calc_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any_grant
);

    int w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_idx     = 0;
        for (int k = 1; k <= N; k++) begin
            w_idx = (int'(last_grant) + k) % N;
            if (enable && !any_grant && req[w_idx]) begin
                any_grant    = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = IW'(w_idx);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/srlz_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : srlz_tx_scheduler
// Brief    : Round-robin word intake and LOAD/SHIFT/GAP sequencing for the PISO.
// Revision : 1.0 - initial release
// ============================================================================
module srlz_tx_scheduler
    import srlz_pkg::*;
#(
    parameter int DATA_WIDTH = c_default_data_width,
    parameter int N_REQ      = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [N_REQ-1:0]              req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]              req_ready,
    output logic                          srl_load,
    output logic [DATA_WIDTH-1:0]         srl_data,
    output logic                          srl_shift,
    output logic [calc_width(N_REQ)-1:0]  ch_id,
    output logic                          tx_busy,
    output logic                          frame_done
);

    localparam int IW = calc_width(N_REQ);
    localparam int CW = calc_width(DATA_WIDTH);
    localparam int GW = calc_width(GAP_CYCLES);

    localparam logic [IW-1:0] c_last_init = IW'(N_REQ - 1);
    localparam logic [CW-1:0] c_last_cnt  = CW'(DATA_WIDTH - 2);
    localparam logic [GW-1:0] c_gap_last  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    logic [1:0]            r_state;
    logic [IW-1:0]         r_last_grant;
    logic [CW-1:0]         r_bit_cnt;
    logic [GW-1:0]         r_gap_cnt;
    logic                  r_srl_load;
    logic                  r_srl_shift;
    logic                  r_frame_done;
    logic                  r_tx_busy;
    logic [DATA_WIDTH-1:0] r_srl_data;
    logic [IW-1:0]         r_ch_id;

    logic [N_REQ-1:0]      w_grant;
    logic [IW-1:0]         w_grant_idx;
    logic                  w_any_grant;
    logic                  w_arb_en;
    logic [DATA_WIDTH-1:0] w_grant_data;

    // Gating the arbiter itself keeps req_ready and the capture decision identical.
    assign w_arb_en = enable && (r_state == c_st_idle);

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (r_last_grant),
        .enable     (w_arb_en),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx),
        .any_grant  (w_any_grant)
    );

    assign w_grant_data = req_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_last_grant <= c_last_init;
            r_bit_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_srl_load   <= 1'b0;
            r_srl_shift  <= 1'b0;
            r_frame_done <= 1'b0;
            r_tx_busy    <= 1'b0;
            r_srl_data   <= '0;
            r_ch_id      <= '0;
        end else begin
            r_srl_load   <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_any_grant) begin
                        r_state      <= c_st_load;
                        r_srl_load   <= 1'b1;
                        r_tx_busy    <= 1'b1;
                        r_srl_data   <= w_grant_data;
                        r_ch_id      <= w_grant_idx;
                        r_last_grant <= w_grant_idx;
                    end
                end
                c_st_load: begin
                    r_state      <= c_st_shift;
                    r_bit_cnt    <= '0;
                    r_srl_shift  <= 1'b1;
                    // Outputs are registered, so frame_done is decided one cycle ahead.
                    r_frame_done <= (c_last_cnt == '0);
                end
                c_st_shift: begin
                    if (r_bit_cnt == c_last_cnt) begin
                        r_srl_shift <= 1'b0;
                        r_gap_cnt   <= '0;
                        if (GAP_CYCLES == 0) begin
                            r_state   <= c_st_idle;
                            r_tx_busy <= 1'b0;
                        end else begin
                            r_state <= c_st_gap;
                        end
                    end else begin
                        r_bit_cnt    <= r_bit_cnt + CW'(1);
                        r_frame_done <= ((r_bit_cnt + CW'(1)) == c_last_cnt);
                    end
                end
                c_st_gap: begin
                    if (r_gap_cnt == c_gap_last) begin
                        r_state   <= c_st_idle;
                        r_tx_busy <= 1'b0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + GW'(1);
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    assign req_ready  = w_grant;
    assign srl_load   = r_srl_load;
    assign srl_shift  = r_srl_shift;
    assign frame_done = r_frame_done;
    assign tx_busy    = r_tx_busy;
    assign srl_data   = r_srl_data;
    assign ch_id      = r_ch_id;

endmodule
`default_nettype wire
